// File: rtl/alu_share_pkg.sv
// Shared constants and types for the ALU sharing arbiter.
// Holds operand widths, the arbiter FSM states and the in-flight tag record.
package alu_share_pkg;

    localparam int A_W      = 18;
    localparam int C_W      = 48;
    localparam int SEL_W    = 2;
    localparam int TAG_ID_W = 3;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: grants the first valid bit at or above ptr,
// wrapping around, and reports the one-hot grant plus its index.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the farthest slot down to the pointer so the nearest valid wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % N]) begin
                grant = N'(1) << ((int'(ptr) + k) % N);
                idx   = IDX_W'((int'(ptr) + k) % N);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU among N_REQ requesters, with
// lockable grants and a tag pipeline that routes each result back to its issuer.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 2,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_lock,
    input  logic [A_W*N_REQ-1:0]   req_a,
    input  logic [A_W*N_REQ-1:0]   req_b,
    input  logic [A_W*N_REQ-1:0]   req_d,
    input  logic [C_W*N_REQ-1:0]   req_c,
    input  logic [N_REQ-1:0]       req_cin,
    input  logic [SEL_W*N_REQ-1:0] req_sel,
    output logic [N_REQ-1:0]       req_ready,
    output logic [A_W-1:0]         alu_a,
    output logic [A_W-1:0]         alu_b,
    output logic [A_W-1:0]         alu_d,
    output logic [C_W-1:0]         alu_c,
    output logic                   alu_cin,
    output logic [SEL_W-1:0]       alu_sel,
    input  logic [C_W-1:0]         alu_p,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [C_W-1:0]         rsp_p
);

    localparam int PTR_W = $clog2(N_REQ);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [A_W-1:0]     alu_a_q, alu_a_d;
    logic [A_W-1:0]     alu_b_q, alu_b_d;
    logic [A_W-1:0]     alu_d_q, alu_d_d;
    logic [C_W-1:0]     alu_c_q, alu_c_d;
    logic               alu_cin_q, alu_cin_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    tag_t               tag_q [ALU_LAT+1];
    tag_t               tag_d [ALU_LAT+1];

    logic [N_REQ-1:0]   rr_gnt;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_any;
    logic [PTR_W-1:0]   win_idx;
    logic               accept;
    tag_t               last_tag;

    rr_grant #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_rr_grant (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (rr_gnt),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Grant selection and lock tracking; a locked owner blocks everyone else.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        req_ready = '0;
        win_idx   = rr_idx;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rr_gnt;
                accept    = rr_any;
                if (rr_any) begin
                    ptr_d = (int'(rr_idx) == N_REQ - 1) ? '0 : rr_idx + 1'b1;
                    if (req_lock[rr_idx]) begin
                        state_d = LOCKED;
                        owner_d = rr_idx;
                    end
                end
            end
            LOCKED: begin
                win_idx = owner_q;
                if (req_valid[owner_q]) begin
                    req_ready = N_REQ'(1) << owner_q;
                    accept    = 1'b1;
                    if (!req_lock[owner_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture holds on idle cycles; the first tag stage parallels it.
    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_d_d   = alu_d_q;
        alu_c_d   = alu_c_q;
        alu_cin_d = alu_cin_q;
        alu_sel_d = alu_sel_q;
        if (accept) begin
            alu_a_d   = req_a[A_W*int'(win_idx) +: A_W];
            alu_b_d   = req_b[A_W*int'(win_idx) +: A_W];
            alu_d_d   = req_d[A_W*int'(win_idx) +: A_W];
            alu_c_d   = req_c[C_W*int'(win_idx) +: C_W];
            alu_cin_d = req_cin[win_idx];
            alu_sel_d = req_sel[SEL_W*int'(win_idx) +: SEL_W];
        end
        tag_d[0] = {accept, TAG_ID_W'(win_idx)};
        for (int i = 1; i <= ALU_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_d_q   <= '0;
            alu_c_q   <= '0;
            alu_cin_q <= 1'b0;
            alu_sel_q <= '0;
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_d_q   <= alu_d_d;
            alu_c_q   <= alu_c_d;
            alu_cin_q <= alu_cin_d;
            alu_sel_q <= alu_sel_d;
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign last_tag = tag_q[ALU_LAT];

    always_comb begin
        rsp_valid = '0;
        rsp_id    = '0;
        if (last_tag.valid) begin
            rsp_valid = N_REQ'(1) << last_tag.id;
            rsp_id    = ID_W'(last_tag.id);
        end
    end

    assign rsp_p   = alu_p;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_d   = alu_d_q;
    assign alu_c   = alu_c_q;
    assign alu_cin = alu_cin_q;
    assign alu_sel = alu_sel_q;

endmodule
